// File: rtl/dict_load_ctrl.sv
// Dictionary field load sequencer: collects N entries, replays them as one gap-free write burst,
// and optionally reads them back (enable with DICT_LOAD_VERIFY_EN).
module dict_load_ctrl #(
    parameter int unsigned KEY_WIDTH = 3,
    parameter int unsigned VAL_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VAL_WIDTH-1:0] in_data,
    output logic                 dict_write_enable,
    output logic [VAL_WIDTH-1:0] dict_write_val,
    output logic [KEY_WIDTH-1:0] dict_key_lookup,
    input  logic [VAL_WIDTH-1:0] dict_val_in,
    output logic                 busy,
    output logic                 done,
    output logic                 load_error
);

    localparam int unsigned N  = 1 << KEY_WIDTH;
    localparam int unsigned IW = KEY_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_BURST   = 3'd2,
`ifdef DICT_LOAD_VERIFY_EN
        S_VERIFY  = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    state_t               state_q, state_nxt;
    logic [IW-1:0]        idx_q, idx_nxt;
    logic [VAL_WIDTH-1:0] entry_buf [N];
    logic                 buf_we;
    logic                 in_ready_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic                 we_nxt;
    logic [VAL_WIDTH-1:0] wval_nxt;
    logic                 last_idx;

    assign last_idx = (idx_q == IW'(N - 1));

`ifdef DICT_LOAD_VERIFY_EN
    logic                 load_err_nxt;
    logic [KEY_WIDTH-1:0] key_nxt;
`endif

    // Next-state, counter and registered-output decode
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        buf_we    = 1'b0;
`ifdef DICT_LOAD_VERIFY_EN
        load_err_nxt = load_error;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_COLLECT;
                    idx_nxt   = '0;
                end
            end
            S_COLLECT: begin
                if (in_valid && in_ready) begin
                    buf_we = 1'b1;
                    if (last_idx) begin
                        state_nxt = S_BURST;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx_q + IW'(1);
                    end
                end
            end
            S_BURST: begin
                if (last_idx) begin
`ifdef DICT_LOAD_VERIFY_EN
                    state_nxt = S_VERIFY;
`else
                    state_nxt = S_DONE;
`endif
                    idx_nxt = '0;
                end else begin
                    idx_nxt = idx_q + IW'(1);
                end
            end
`ifdef DICT_LOAD_VERIFY_EN
            S_VERIFY: begin
                if (dict_val_in != entry_buf[idx_q[KEY_WIDTH-1:0]]) begin
                    load_err_nxt = 1'b1;
                end
                if (last_idx) begin
                    state_nxt = S_DONE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx_q + IW'(1);
                end
            end
`endif
            S_DONE: begin
                if (start) begin
                    state_nxt = S_COLLECT;
                    idx_nxt   = '0;
`ifdef DICT_LOAD_VERIFY_EN
                    load_err_nxt = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase

        in_ready_nxt = (state_nxt == S_COLLECT);
        done_nxt     = (state_nxt == S_DONE);
        we_nxt       = (state_nxt == S_BURST);
        busy_nxt     = (state_nxt == S_COLLECT) || (state_nxt == S_BURST);
`ifdef DICT_LOAD_VERIFY_EN
        busy_nxt     = busy_nxt || (state_nxt == S_VERIFY);
        key_nxt      = (state_nxt == S_VERIFY) ? idx_nxt[KEY_WIDTH-1:0] : '0;
`endif
        wval_nxt     = we_nxt ? entry_buf[idx_nxt[KEY_WIDTH-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            idx_q             <= '0;
            in_ready          <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            dict_write_enable <= 1'b0;
            dict_write_val    <= '0;
        end else begin
            state_q           <= state_nxt;
            idx_q             <= idx_nxt;
            in_ready          <= in_ready_nxt;
            busy              <= busy_nxt;
            done              <= done_nxt;
            dict_write_enable <= we_nxt;
            dict_write_val    <= wval_nxt;
        end
    end

    // Entry storage needs no reset: it is always rewritten before being replayed
    always_ff @(posedge clk) begin
        if (buf_we) begin
            entry_buf[idx_q[KEY_WIDTH-1:0]] <= in_data;
        end
    end

`ifdef DICT_LOAD_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_error      <= 1'b0;
            dict_key_lookup <= '0;
        end else begin
            load_error      <= load_err_nxt;
            dict_key_lookup <= key_nxt;
        end
    end
`else
    logic unused_val_in;
    assign unused_val_in   = ^dict_val_in;
    assign load_error      = 1'b0;
    assign dict_key_lookup = '0;
`endif

endmodule

// File: tb/tb_dict_load_ctrl.sv
// Self-checking bench for dict_load_ctrl: table-driven loads, reset/restart corners and random loads
// against a behavioural source/dictionary model.
module tb_dict_load_ctrl;

    localparam int KW = 3;
    localparam int VW = 7;
    localparam int N  = 8;
`ifdef DICT_LOAD_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_ready;
    logic [VW-1:0] in_data;
    logic          dict_write_enable;
    logic [VW-1:0] dict_write_val;
    logic [KW-1:0] dict_key_lookup;
    logic [VW-1:0] dict_val_in;
    logic          busy, done, load_error;

    dict_load_ctrl #(.KEY_WIDTH(KW), .VAL_WIDTH(VW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dict_write_enable(dict_write_enable), .dict_write_val(dict_write_val),
        .dict_key_lookup(dict_key_lookup), .dict_val_in(dict_val_in),
        .busy(busy), .done(done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    // Dictionary model: write pointer restarts whenever write enable is low
    logic [VW-1:0] dmem [N];
    int            dptr = 0;
    bit            corrupt = 1'b0;
    always @(posedge clk) begin
        if (dict_write_enable) begin
            dmem[dptr % N] <= dict_write_val;
            dptr <= dptr + 1;
        end else begin
            dptr <= 0;
        end
    end
    assign dict_val_in = (corrupt && dict_key_lookup == KW'(5)) ? '0 : dmem[dict_key_lookup];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [VW-1:0] cur_data [N];
    bit            vmask [200];

    function automatic bit valid_at(input int mode, input int j);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (j % 2) == 0;
        return vmask[j];
    endfunction

    // Observation index of the Nth accepted entry, counting from the start cycle
    function automatic int calc_c(input int mode);
        int acc = 0;
        for (int j = 1; j < 200; j++) begin
            if (valid_at(mode, j)) acc++;
            if (acc == N) return j;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input int mode, input bit corr, input bit sib,
                            input int abort_at, input int exp_c, input bit exp_err);
        int acc = 0, done_obs = -1, err_obs = -1, runs = 0, busy_cnt = 0;
        int rdy_cnt = 0, viol = 0, kviol = 0, nmis = 0, vstart;
        bit prev_we = 1'b0, rdy_prev;
        bit aborted = 1'b0;
        logic [VW-1:0] got [$];
        corrupt  = corr;
        vstart   = exp_c + N + 1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = cur_data[0];
        rdy_prev = in_ready;
        for (int j = 1; j < 200 && done_obs < 0 && !aborted; j++) begin
            step();
            start = 1'b0;
            if (in_valid && rdy_prev) acc++;
            if (j == 1) check("restart_state", {in_ready, done, load_error, busy}, 4'b1001);
            if (in_ready) rdy_cnt++;
            if (busy) busy_cnt++;
            if (dict_write_enable) begin
                got.push_back(dict_write_val);
                if (!prev_we) runs++;
            end else if (dict_write_val != '0) begin
                viol++;
            end
            prev_we = dict_write_enable;
            if (VER && j >= vstart && j < vstart + N) begin
                if (int'(dict_key_lookup) != j - vstart) kviol++;
            end else if (dict_key_lookup != '0) begin
                kviol++;
            end
            if (load_error && err_obs < 0) err_obs = j;
            if (done) done_obs = j;
            if (sib && j == exp_c + 3) start = 1'b1;
            if (acc < N) begin
                in_valid = valid_at(mode, j);
                in_data  = cur_data[acc];
            end else begin
                in_valid = 1'b1;
                in_data  = 7'h7f;
            end
            rdy_prev = in_ready;
            if (abort_at > 0 && j == abort_at) aborted = 1'b1;
        end
        if (aborted) begin
            reset = 1'b1;
            step();
            reset    = 1'b0;
            in_valid = 1'b0;
            check("reset_outs", {in_ready, busy, done, dict_write_enable, load_error,
                                 dict_key_lookup != '0, dict_write_val != '0}, 0);
            step();
            check("reset_idle", {in_ready, busy, dict_write_enable}, 0);
            return;
        end
        check("done_latency", done_obs, exp_c + (VER ? 2 * N : N) + 1);
        check("collect_len", rdy_cnt, exp_c);
        check("burst_len", got.size(), N);
        check("burst_runs", runs, 1);
        for (int i = 0; i < N && i < got.size(); i++)
            if (got[i] != cur_data[i]) nmis++;
        check("burst_vals", nmis, 0);
        nmis = 0;
        for (int i = 0; i < N; i++)
            if (dmem[i] != cur_data[i]) nmis++;
        check("dict_image", nmis, 0);
        check("load_error", load_error, int'(exp_err && VER));
        if (exp_err && VER) check("err_timing", err_obs, vstart + 5 + 1);
        check("busy_cycles", busy_cnt, done_obs - 1);
        check("idle_write_val", viol, 0);
        check("key_lookup_seq", kviol, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("done_hold", {done, in_ready, busy}, 3'b100);
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        int mode;
        int base;
        bit corr;
        bit sib;
        int abort_at;
        int exp_c;
        bit exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 'h10, 1'b0, 1'b0, 0,  8, 1'b0};
        vecs[1] = '{1, 'h10, 1'b0, 1'b0, 0, 16, 1'b0};
        vecs[2] = '{0, 'h10, 1'b1, 1'b0, 0,  8, 1'b1};
        vecs[3] = '{0, 'h20, 1'b0, 1'b1, 0,  8, 1'b0};
        vecs[4] = '{0, 'h10, 1'b0, 1'b0, 4,  8, 1'b0};
        vecs[5] = '{0, 'h30, 1'b0, 1'b0, 0,  8, 1'b0};
        vecs[6] = '{0, 'h10, 1'b0, 1'b0, 13, 8, 1'b0};
        vecs[7] = '{1, 'h40, 1'b0, 1'b0, 0, 16, 1'b0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        step();
        step();
        check("reset_state", {in_ready, dict_write_enable, dict_write_val != '0,
                              dict_key_lookup != '0, busy, done, load_error}, 0);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 7'h55;
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_ready", {in_ready, busy}, 0);
        end

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) cur_data[i] = VW'(vecs[v].base + i);
            run_load(vecs[v].mode, vecs[v].corr, vecs[v].sib, vecs[v].abort_at,
                     vecs[v].exp_c, vecs[v].exp_err);
        end

        for (int r = 0; r < 6; r++) begin
            bit corr;
            for (int i = 0; i < N; i++) cur_data[i] = VW'($urandom_range(0, 127));
            for (int j = 0; j < 200; j++) vmask[j] = (j >= 100) || ($urandom_range(0, 2) != 0);
            corr = ($urandom_range(0, 1) == 1);
            run_load(2, corr, 1'b0, 0, calc_c(2), corr && (cur_data[5] != '0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dict_load_ctrl.md
# dict_load_ctrl

Sequencer that initialises one dictionary field at startup. It accepts dictionary entries from an upstream source over a valid/ready stream at any rate, buffers them, and then replays them to the dictionary's write port as one gap-free burst. The burst must be gap-free because the dictionary's write pointer resets whenever its write enable drops. Optionally, the block reads every entry back through the dictionary's key-lookup path and flags mismatches. It sits between the boot/config loader and a dictionary field instance, and tells the compressor/decompressor when the table is valid.

## Interface
- KEY_WIDTH, 3, dictionary index width; N = 2**KEY_WIDTH entries
- VAL_WIDTH, 7, uncompressed field width
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a load; ignored unless state is IDLE or DONE
- in_valid  in  1  upstream entry valid
- in_ready  out  1  high only in COLLECT
- in_data  in  VAL_WIDTH  entry value; entries arrive in key order 0..N-1
- dict_write_enable  out  1  to dictionary write_enable
- dict_write_val  out  VAL_WIDTH  to dictionary write_val
- dict_key_lookup  out  KEY_WIDTH  to dictionary key_lookup_in (verify only)
- dict_val_in  in  VAL_WIDTH  from dictionary val_out (combinational read)
- busy  out  1  high in COLLECT, BURST, VERIFY
- done  out  1  high in DONE; dictionary contents valid
- load_error  out  1  sticky readback mismatch flag

## Operation
- Storage: buf[0..N-1] of VAL_WIDTH; counter idx of KEY_WIDTH+1 bits.
- IDLE: all outputs 0. start -> COLLECT, idx=0.
- COLLECT: in_ready=1. On in_valid&&in_ready: buf[idx]=in_data, idx++. On the Nth accept -> BURST, idx=0. Bubbles on in_valid are allowed, with no timeout.
- BURST: dict_write_enable=1, dict_write_val=buf[idx[KEY_WIDTH-1:0]] for exactly N consecutive cycles, idx 0..N-1. After the cycle with idx=N-1 -> VERIFY (macro on) or DONE. dict_write_enable is never low inside BURST.
- VERIFY: dict_key_lookup=idx, compare dict_val_in with buf[idx] in the same cycle. On mismatch, set load_error (sticky). Runs for N cycles, then -> DONE.
- DONE: done=1 and held. start -> COLLECT, clears load_error and done, idx=0.
- start in COLLECT, BURST or VERIFY is ignored.
- reset in any state -> IDLE, idx=0, load_error=0, outputs 0 next cycle. A partial dictionary image is not cleaned up and is not valid until done.
- Outside BURST: dict_write_enable=0 and dict_write_val=0. Outside VERIFY: dict_key_lookup=0.

## Timing
- Reset values: in_ready=0, dict_write_enable=0, dict_write_val=0, dict_key_lookup=0, busy=0, done=0, load_error=0.
- All outputs are registered-state decodes (Moore). in_ready does not depend on in_valid.
- start sampled at edge t gives COLLECT during cycle t+1.
- With in_valid held high, COLLECT lasts N cycles, BURST lasts N cycles, and VERIFY lasts N cycles.
- Latency from start to done is 2N+1 cycles without verify and 3N+1 cycles with verify.
- The dictionary needs write_enable low for at least one cycle before BURST so its write pointer is 0. This is guaranteed because COLLECT always precedes BURST.
- load_error is updated at the edge ending the mismatching VERIFY cycle and is visible from the next cycle.

## Configuration
- DICT_LOAD_VERIFY_EN defined:
  - VERIFY state exists.
  - dict_key_lookup is driven during VERIFY.
  - load_error is live.
- DICT_LOAD_VERIFY_EN undefined:
  - BURST -> DONE directly.
  - dict_key_lookup is tied 0 and load_error is tied 0.
  - dict_val_in is unused.

## Test plan
- Reset, then start with in_valid high and in_data 0x10..0x17 (N=8): in_ready high for 8 cycles, then dict_write_enable high for exactly 8 cycles with write_val 0x10..0x17. done asserts 17 cycles after start (verify off) or 25 cycles after start (verify on), and load_error=0.
- Same load with in_valid toggling every other cycle: COLLECT takes 16 cycles, and the BURST is still 8 contiguous cycles with identical values.
- Verify on, with a bench dictionary model forcing val_out[key 5]=0x00 against a stored value 0x15: load_error=1 from the cycle after key 5 is checked, and done still asserts.
- start pulsed during BURST: ignored, with burst length and values unchanged. start pulsed in DONE: done drops next cycle, load_error clears, COLLECT restarts.
- reset asserted mid-COLLECT (after 3 accepts) and mid-BURST (at idx 4): next cycle IDLE, dict_write_enable=0, and a subsequent full load completes correctly.
- in_valid high while in IDLE or DONE: in_ready=0, and no entry is consumed.
